display_bank: RTL and testbench

Parametrised multi-channel display output block attached to the processor's output side. It generalises the single 8-bit `display_o` port into a bank of `CHANNELS` registers of `WIDTH` bits each. Every register supports write/set/clear/toggle updates and registered readback. A prescaled scan engine time-multiplexes the bank onto one shared `display_o` bus, with a one-hot channel select and a per-frame pulse.

---
 rtl/display_bank_if.sv | 24 ++
 rtl/display_bank.sv | 68 ++++++
 tb/tb_display_bank.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/display_bank_if.sv
// display_bank_if: update/readback strobes and scanned display outputs of the display bank
interface display_bank_if #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic wr_en_i;
  logic [1:0] wr_op_i;
  logic [AW-1:0] wr_addr_i;
  logic [WIDTH-1:0] wr_data_i;
  logic [AW-1:0] rd_addr_i;
  logic [WIDTH-1:0] rd_data_o;
  logic [WIDTH-1:0] display_o;
  logic [CHANNELS-1:0] select_o;
  logic frame_o;
  modport master (
    output wr_en_i, wr_op_i, wr_addr_i, wr_data_i, rd_addr_i,
    input rd_data_o, display_o, select_o, frame_o
  );
  modport slave (
    input wr_en_i, wr_op_i, wr_addr_i, wr_data_i, rd_addr_i,
    output rd_data_o, display_o, select_o, frame_o
  );
endinterface

// File: rtl/display_bank.sv
// display_bank: channel register bank with set/clear/toggle updates, readback and prescaled scan-out
module display_bank #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int DIV = 1000
) (
  input logic clk,
  input logic reset_i,
  display_bank_if.slave bus
);
  localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [AW:0] NCH = (AW+1)'(CHANNELS);
  localparam logic [AW-1:0] SCAN_0 = '0;
  localparam logic [AW-1:0] SCAN_LAST = AW'(CHANNELS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  logic [WIDTH-1:0] bank_q [CHANNELS];
  logic [WIDTH-1:0] bank_d [CHANNELS];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] rd_q, rd_d, disp_q, disp_d, cur, upd;
  logic [CHANNELS-1:0] sel_q, sel_d;
  logic frame_q, frame_d, tick, wr_hit, rd_hit;
  assign tick = cnt_q == CNT_MAX;
  assign wr_hit = bus.wr_en_i && ({1'b0, bus.wr_addr_i} < NCH);
  assign rd_hit = {1'b0, bus.rd_addr_i} < NCH;
  assign cur = bank_q[bus.wr_addr_i];
  assign upd = bus.wr_op_i == 2'b00 ? bus.wr_data_i :
               bus.wr_op_i == 2'b01 ? cur | bus.wr_data_i :
               bus.wr_op_i == 2'b10 ? cur & ~bus.wr_data_i : cur ^ bus.wr_data_i;
  always_comb begin
    bank_d = bank_q;
    if (wr_hit) bank_d[bus.wr_addr_i] = upd;
  end
  // scan-out reads the pre-edge bank at the index being entered, so select and data move together
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = !tick ? idx_q : (idx_q == SCAN_LAST ? SCAN_0 : idx_q + AW'(1));
    rd_d = rd_hit ? bank_q[bus.rd_addr_i] : '0;
    disp_d = bank_q[idx_d];
    sel_d = '0;
    sel_d[idx_d] = 1'b1;
    frame_d = tick && idx_d == SCAN_0;
  end
  always_ff @(posedge clk) begin
    if (reset_i) begin
      bank_q <= '{default: '0};
      cnt_q <= '0;
      idx_q <= SCAN_0;
      rd_q <= '0;
      disp_q <= '0;
      sel_q <= CHANNELS'(1);
      frame_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      rd_q <= rd_d;
      disp_q <= disp_d;
      sel_q <= sel_d;
      frame_q <= frame_d;
    end
  end
  assign bus.rd_data_o = rd_q;
  assign bus.display_o = disp_q;
  assign bus.select_o = sel_q;
  assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_display_bank.sv
// tb_display_bank: table, sequence and random checks of display_bank against an arithmetic scan model
module tb_display_bank;
  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] res;
  } op_vec_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int passed = 0;
  int k = 0;
  logic [7:0] mb [4];
  logic [7:0] mb3 [3];
  always #5 clk = ~clk;
  display_bank_if #(.WIDTH(8), .CHANNELS(4)) bus ();
  display_bank_if #(.WIDTH(8), .CHANNELS(3)) bus3 ();
  display_bank_if #(.WIDTH(8), .CHANNELS(1)) bus1 ();
  display_bank #(.WIDTH(8), .CHANNELS(4), .DIV(4)) dut (.clk(clk), .reset_i(rst), .bus(bus.slave));
  display_bank #(.WIDTH(8), .CHANNELS(3), .DIV(2)) dut3 (.clk(clk), .reset_i(rst), .bus(bus3.slave));
  display_bank #(.WIDTH(8), .CHANNELS(1), .DIV(1)) dut1 (.clk(clk), .reset_i(rst), .bus(bus1.slave));

  function automatic logic [7:0] apply(logic [1:0] op, logic [7:0] cur, logic [7:0] d);
    case (op)
      2'd0: return d;
      2'd1: return cur | d;
      2'd2: return cur & ~d;
      default: return cur ^ d;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    bus.wr_en_i = 1'b0; bus.wr_op_i = 2'd0; bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.rd_addr_i = '0;
    bus3.wr_en_i = 1'b0; bus3.wr_op_i = 2'd0; bus3.wr_addr_i = '0; bus3.wr_data_i = '0; bus3.rd_addr_i = '0;
    bus1.wr_en_i = 1'b0; bus1.wr_op_i = 2'd0; bus1.wr_addr_i = '0; bus1.wr_data_i = '0; bus1.rd_addr_i = '0;
  endtask

  task automatic wr(int a, logic [1:0] op, logic [7:0] d);
    bus.wr_en_i = 1'b1; bus.wr_op_i = op; bus.wr_addr_i = 2'(a); bus.wr_data_i = d;
  endtask

  // k counts edges since reset release; the scanned index is simply (k / DIV) mod CHANNELS
  task automatic step();
    logic [7:0] pre [4];
    logic [7:0] pre3 [3];
    logic [7:0] e_disp, e_rd, e_disp3;
    logic [3:0] e_sel;
    logic [2:0] e_sel3;
    logic e_frame, e_frame3;
    int a;
    pre = mb;
    pre3 = mb3;
    @(posedge clk);
    if (rst) begin
      k = 0;
      mb = '{default: 8'h00};
      mb3 = '{default: 8'h00};
      e_disp = 0; e_rd = 0; e_sel = 4'b0001; e_frame = 0;
      e_disp3 = 0; e_sel3 = 3'b001; e_frame3 = 0;
    end else begin
      k++;
      e_disp = pre[(k / 4) % 4];
      e_sel = 4'(1 << ((k / 4) % 4));
      e_frame = (k % 16) == 0;
      e_rd = pre[int'(bus.rd_addr_i)];
      if (bus.wr_en_i) begin
        a = int'(bus.wr_addr_i);
        mb[a] = apply(bus.wr_op_i, pre[a], bus.wr_data_i);
      end
      e_disp3 = pre3[(k / 2) % 3];
      e_sel3 = 3'(1 << ((k / 2) % 3));
      e_frame3 = (k % 6) == 0;
      a = int'(bus3.wr_addr_i);
      if (bus3.wr_en_i && a < 3) mb3[a] = apply(bus3.wr_op_i, pre3[a], bus3.wr_data_i);
    end
    #1;
    chk("display", 32'(bus.display_o), 32'(e_disp));
    chk("select", 32'(bus.select_o), 32'(e_sel));
    chk("frame", 32'(bus.frame_o), 32'(e_frame));
    chk("rd_data", 32'(bus.rd_data_o), 32'(e_rd));
    chk("display3", 32'(bus3.display_o), 32'(e_disp3));
    chk("select3", 32'(bus3.select_o), 32'(e_sel3));
    chk("frame3", 32'(bus3.frame_o), 32'(e_frame3));
    chk("select1", 32'(bus1.select_o), 32'd1);
    chk("frame1", 32'(bus1.frame_o), rst ? 32'd0 : 32'd1);
  endtask

  initial begin
    op_vec_t vecs [4];
    logic [7:0] loads [4];
    int nf;
    int guard;
    vecs[0] = '{op: 2'd0, data: 8'hF0, res: 8'hF0};
    vecs[1] = '{op: 2'd1, data: 8'h0F, res: 8'hFF};
    vecs[2] = '{op: 2'd2, data: 8'h3C, res: 8'hC3};
    vecs[3] = '{op: 2'd3, data: 8'hFF, res: 8'h3C};
    loads = '{8'hA5, 8'h3C, 8'hFF, 8'h01};
    rst = 1'b1;
    idle();
    for (int i = 0; i < 2; i++) begin
      bus.wr_en_i = 1'($urandom); bus.wr_op_i = 2'($urandom); bus.wr_addr_i = 2'($urandom);
      bus.wr_data_i = 8'($urandom); bus.rd_addr_i = 2'($urandom);
      step();
      chk("reset_display", 32'(bus.display_o), 32'd0);
      chk("reset_select", 32'(bus.select_o), 32'b0001);
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      wr(i, 2'd0, loads[i]);
      step();
    end
    idle();
    nf = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (bus.frame_o) nf++;
    end
    chk("frame_count_32", 32'(nf), 32'd2);
    for (int i = 0; i < 4; i++) begin
      wr(1, vecs[i].op, vecs[i].data);
      bus.rd_addr_i = 2'd1;
      step();
      idle();
      bus.rd_addr_i = 2'd1;
      step();
      chk("op_readback", 32'(bus.rd_data_o), 32'(vecs[i].res));
    end
    wr(2, 2'd0, 8'h00);
    step();
    wr(2, 2'd0, 8'h55);
    bus.rd_addr_i = 2'd2;
    step();
    chk("rdw_old", 32'(bus.rd_data_o), 32'h00);
    idle();
    bus.rd_addr_i = 2'd2;
    step();
    chk("rdw_new", 32'(bus.rd_data_o), 32'h55);
    for (int i = 0; i < 300; i++) begin
      bus.wr_en_i = 1'($urandom); bus.wr_op_i = 2'($urandom); bus.wr_addr_i = 2'($urandom);
      bus.wr_data_i = 8'($urandom); bus.rd_addr_i = 2'($urandom);
      step();
    end
    idle();
    wr(0, 2'd0, 8'h11);
    step();
    idle();
    guard = 0;
    while (((k / 4) % 4) != 2 && guard < 16) begin
      step();
      guard++;
    end
    chk("reach_scan2", 32'(bus.select_o), 32'b0100);
    rst = 1'b1;
    step();
    chk("midscan_reset_sel", 32'(bus.select_o), 32'b0001);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bus.rd_addr_i = 2'(j);
      step();
      chk("post_reset_rd", 32'(bus.rd_data_o), 32'd0);
      chk("post_reset_sel", 32'(bus.select_o), j == 3 ? 32'b0010 : 32'b0001);
    end
    idle();
    bus3.wr_en_i = 1'b1; bus3.wr_addr_i = 2'd3; bus3.wr_data_i = 8'hAA;
    step();
    bus3.wr_en_i = 1'b0;
    for (int j = 3; j >= 0; j--) begin
      bus3.rd_addr_i = 2'(j);
      step();
      chk("ch3_ignored", 32'(bus3.rd_data_o), 32'd0);
    end
    bus3.wr_en_i = 1'b1; bus3.wr_addr_i = 2'd2; bus3.wr_data_i = 8'h77;
    step();
    bus3.wr_en_i = 1'b0; bus3.rd_addr_i = 2'd2;
    step();
    chk("ch3_write2", 32'(bus3.rd_data_o), 32'h77);
    for (int i = 0; i < 8; i++) step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
